// File: rtl/writeback_pkg.sv
// Shared types for the writeback stage: execute result bundle,
// writeback FSM states and the reset PC.
package writeback_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            wen;
    logic [XLEN-1:0] val;
    logic            redirect;
    logic [XLEN-1:0] target;
  } exec_result_t;

  typedef enum logic {
    WB_RUN,
    WB_SQUASH
  } wb_state_t;

endpackage

// File: rtl/writeback_regfile.sv
// Architectural register file: NREG x XLEN, two async read ports,
// one write port, x0 reads zero, same-cycle write-through bypass.
module writeback_regfile
  import writeback_pkg::*;
#(
  parameter int NREG_P = NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] mem [NREG_P];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG_P; i++)
        mem[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = mem[raddr_a];
    if (raddr_a == 5'd0)
      rdata_a = '0;
    else if (we && waddr == raddr_a)
      rdata_a = wdata;
  end

  always_comb begin
    rdata_b = mem[raddr_b];
    if (raddr_b == 5'd0)
      rdata_b = '0;
    else if (we && waddr == raddr_b)
      rdata_b = wdata;
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: commits execute results into the register file,
// serves decode reads, flushes on redirect, squashes wrong-path work.
// Ports: result (valid/ready/struct), rs1/rs2 read ports,
// flush/flush_pc redirect pulse, instret retired count.
module writeback
  import writeback_pkg::*;
#(
  parameter int              NREG_P     = NREG,
  parameter logic [XLEN-1:0] RESET_PC_P = RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            result_valid,
  output logic            result_ready,
  input  exec_result_t    result,
  input  logic [4:0]      rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  output logic            flush,
  output logic [XLEN-1:0] flush_pc,
  output logic [63:0]     instret
);

  wb_state_t       state_q;
  wb_state_t       state_d;
  logic [XLEN-1:0] exp_pc;
  logic [63:0]     instret_q;
  logic            accept;
  logic            commit;
  logic            rf_we;

  assign result_ready = 1'b1;
  assign instret      = instret_q;

  // In RUN every result is on the right path; in SQUASH only the
  // redirect target may retire.
  always_comb begin
    accept  = (state_q == WB_RUN) || (result.pc == exp_pc);
    commit  = result_valid && accept;
    rf_we   = commit && result.wen;
    state_d = state_q;
    if (commit)
      state_d = result.redirect ? WB_SQUASH : WB_RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WB_RUN;
      exp_pc    <= RESET_PC_P;
      flush     <= 1'b0;
      flush_pc  <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      flush   <= commit && result.redirect;
      if (commit) begin
        instret_q <= instret_q + 64'd1;
        if (result.redirect) begin
          exp_pc   <= result.target;
          flush_pc <= result.target;
        end else begin
          exp_pc <= result.pc + XLEN'(4);
        end
      end
    end
  end

  writeback_regfile #(
    .NREG_P (NREG_P)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (result.rd),
    .wdata   (result.val),
    .raddr_a (rs1_addr),
    .rdata_a (rs1_data),
    .raddr_b (rs2_addr),
    .rdata_b (rs2_data)
  );

endmodule
